// File: rtl/mmbf_cfg_loader.sv
// Streams the halfband cascade configuration image from coefficient memory.
// Optional WAIT_DONE watchdog enabled by defining MMBF_CFG_TIMEOUT_EN.
module mmbf_cfg_loader #(
  parameter int NMHBF_MAX        = 5,
  parameter int COEFF_WIDTH      = 24,
  parameter int FILTER_MAX_ORDER = 32,
  parameter int CFG_LEN          = (FILTER_MAX_ORDER + 3) * NMHBF_MAX,
  parameter int CFG_ADDR_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Cfg_Start,
  output logic                      Cfg_Busy,
  output logic                      Cfg_Done,
  output logic                      Cfg_Error,
  output logic                      Mem_Rd_En,
  output logic [CFG_ADDR_WIDTH-1:0] Mem_Addr,
  input  logic [COEFF_WIDTH-1:0]    Mem_Data,
  output logic                      isConfig,
  input  logic                      isConfigACK,
  input  logic                      isConfigDone,
  output logic [COEFF_WIDTH-1:0]    Data_Config
);

  localparam int AW = CFG_ADDR_WIDTH;
  localparam int W  = COEFF_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(CFG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_SEND,
    S_WAIT
  } state_e;

  state_e        state_q;
  logic          busy_q;
  logic          done_q;
  logic          dvld_q;
  logic          rd_end_q;
  logic          out_v_q;
  logic          spr_v_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] snd_cnt_q;
  logic [W-1:0]  out_q;
  logic [W-1:0]  spr_q;

  logic          ack;
  logic          rd_en;
  logic [1:0]    occ;

`ifdef MMBF_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic          err_q;
  logic [TW-1:0] tmo_q;
  assign Cfg_Error = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign Cfg_Error  = 1'b0;
`endif

  // Prefetch: read whenever a buffer slot (out, spare, or in-flight)
  // frees up this cycle; the read is a same-cycle response to ACK so
  // a sustained ACK sees one word per cycle.
  always_comb begin
    ack   = (state_q == S_SEND) && out_v_q && isConfigACK;
    occ   = 2'(out_v_q) + 2'(spr_v_q) + 2'(dvld_q);
    rd_en = 1'b0;
    if ((state_q == S_PRIME || state_q == S_SEND) && !rd_end_q)
      rd_en = ack ? (occ != 2'd3) : (occ < 2'd2);
  end

  // Transfer FSM, read pointer, output/spare word registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dvld_q    <= 1'b0;
      rd_end_q  <= 1'b0;
      out_v_q   <= 1'b0;
      spr_v_q   <= 1'b0;
      rd_ptr_q  <= '0;
      snd_cnt_q <= '0;
      out_q     <= '0;
      spr_q     <= '0;
`ifdef MMBF_CFG_TIMEOUT_EN
      err_q     <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      dvld_q <= rd_en;
      if (rd_en) begin
        if (rd_ptr_q == LAST)
          rd_end_q <= 1'b1;
        else
          rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (Cfg_Start) begin
            state_q   <= S_PRIME;
            busy_q    <= 1'b1;
            rd_ptr_q  <= '0;
            rd_end_q  <= 1'b0;
            snd_cnt_q <= '0;
`ifdef MMBF_CFG_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        S_PRIME: begin
          if (dvld_q) begin
            out_q   <= Mem_Data;
            out_v_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (ack) begin
            if (snd_cnt_q == LAST) begin
              out_q   <= '0;
              out_v_q <= 1'b0;
              spr_v_q <= 1'b0;
              state_q <= S_WAIT;
`ifdef MMBF_CFG_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end else begin
              snd_cnt_q <= snd_cnt_q + AW'(1);
              if (spr_v_q) begin
                out_q   <= spr_q;
                spr_q   <= Mem_Data;
                spr_v_q <= dvld_q;
              end else begin
                out_q   <= Mem_Data;
              end
            end
          end else if (dvld_q) begin
            spr_q   <= Mem_Data;
            spr_v_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (isConfigDone) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`ifdef MMBF_CFG_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
      endcase
    end
  end

  assign Cfg_Busy    = busy_q;
  assign Cfg_Done    = done_q;
  assign Mem_Rd_En   = rd_en;
  assign Mem_Addr    = rd_ptr_q;
  assign isConfig    = out_v_q;
  assign Data_Config = out_q;

endmodule

// File: tb/tb_mmbf_cfg_loader.sv
// Randomized bench for mmbf_cfg_loader against an in-order word model.
// Exercises the watchdog path when MMBF_CFG_TIMEOUT_EN is defined.
module tb_mmbf_cfg_loader;

  localparam int W   = 24;
  localparam int AW  = 8;
  localparam int LEN = 175;
`ifdef MMBF_CFG_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [W-1:0]  rdata;
  logic          cfg;
  logic          ack;
  logic          cdone;
  logic [W-1:0]  dcfg;

  logic [W-1:0]  mem [LEN];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en && addr < AW'(LEN)) rdata <= mem[addr];

  mmbf_cfg_loader #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .Cfg_Start   (start),
    .Cfg_Busy    (busy),
    .Cfg_Done    (done),
    .Cfg_Error   (err),
    .Mem_Rd_En   (rd_en),
    .Mem_Addr    (addr),
    .Mem_Data    (rdata),
    .isConfig    (cfg),
    .isConfigACK (ack),
    .isConfigDone(cdone),
    .Data_Config (dcfg)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"},  32'(err), 0);
    chk({tag, "_rd"},   32'(rd_en), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_cfg"},  32'(cfg), 0);
    chk({tag, "_data"}, 32'(dcfg), 0);
  endtask

  // mode 0: ACK always, 1: every 3rd cycle with gaps, 2: random ACK
  task automatic xfer(input int mode, input bit poke,
                      input int abort_at, input bit exp_tmo);
    int idx;
    int rd_exp;
    int cyc;
    int guard;
    int nwait;
    bit a;
    start = 1'b1;
    ack   = 1'b0;
    tick();
    start = 1'b0;
    ack   = 1'($urandom_range(1));
    chk("busy_on", 32'(busy), 1);
    chk("err_clr", 32'(err), 0);
    chk("cfg_prime1", 32'(cfg), 0);
    #1;
    chk("rd_c1", 32'(rd_en), 1);
    chk("addr_c1", 32'(addr), 0);
    tick();
    ack = 1'($urandom_range(1));
    chk("cfg_prime2", 32'(cfg), 0);
    #1;
    chk("rd_c2", 32'(rd_en), 1);
    chk("addr_c2", 32'(addr), 1);
    tick();
    rd_exp = 2;
    idx    = 0;
    cyc    = 3;
    guard  = 0;
    while (idx < LEN && guard < 4000) begin
      chk("cfg_on", 32'(cfg), 1);
      chk("data", 32'(dcfg), 32'(mem[idx]));
      unique case (mode)
        0: a = 1'b1;
        1: a = (cyc % 3 == 0) && ($urandom_range(3) != 0);
        default: a = 1'($urandom_range(1));
      endcase
      ack = a;
      if (poke) start = 1'($urandom_range(1));
      #1;
      if (rd_en) begin
        chk("rd_addr", 32'(addr), rd_exp);
        chk("rd_range", 32'(rd_exp < LEN), 1);
        rd_exp++;
      end
      if (a) idx++;
      if (abort_at > 0 && idx == abort_at) begin
        rst   = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        tick();
        chk_zero("abort");
        rst = 1'b0;
        return;
      end
      tick();
      cyc++;
      guard++;
    end
    chk("send_budget", idx, LEN);
    chk("rd_total", rd_exp, LEN);
    ack   = 1'($urandom_range(1));
    start = poke ? 1'($urandom_range(1)) : 1'b0;
    chk("cfg_off", 32'(cfg), 0);
    chk("data_off", 32'(dcfg), 0);
    chk("busy_wait", 32'(busy), 1);
    if (exp_tmo) begin
      for (int w = 0; w < 16; w++) begin
        chk("tmo_err0", 32'(err), 0);
        chk("tmo_busy", 32'(busy), 1);
        chk("tmo_done0", 32'(done), 0);
        ack = 1'($urandom_range(1));
        tick();
      end
      chk("tmo_err1", 32'(err), 1);
      chk("tmo_busy0", 32'(busy), 0);
      chk("tmo_nodone", 32'(done), 0);
      start = 1'b0;
      tick();
      chk("tmo_sticky", 32'(err), 1);
      chk("tmo_nodone2", 32'(done), 0);
      return;
    end
    nwait = $urandom_range(6);
    for (int w = 0; w < nwait; w++) begin
      chk("wait_busy", 32'(busy), 1);
      chk("wait_done0", 32'(done), 0);
      ack = 1'($urandom_range(1));
      if (poke) start = 1'($urandom_range(1));
      tick();
    end
    start = 1'b0;
    ack   = 1'b0;
    cdone = 1'b1;
    tick();
    cdone = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("done_busy0", 32'(busy), 0);
    chk("done_err0", 32'(err), 0);
    tick();
    chk("done_once", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cfg", 32'(cfg), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    cdone = 1'b0;
    for (int i = 0; i < LEN; i++) mem[i] = W'(i + 'h100);
    tick();
    tick();
    chk_zero("rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack   = 1'b1;
      cdone = 1'b1;
      tick();
      chk_zero("idle");
    end
    ack   = 1'b0;
    cdone = 1'b0;
    xfer(0, 1'b0, 0, 1'b0);
    for (int i = 0; i < LEN; i++) mem[i] = W'($urandom);
    xfer(1, 1'b0, 0, 1'b0);
    xfer(2, 1'b1, 0, 1'b0);
    for (int i = 0; i < LEN; i++) mem[i] = W'($urandom);
    xfer(2, 1'b0, 50, 1'b0);
    xfer(0, 1'b1, 0, 1'b0);
`ifdef MMBF_CFG_TIMEOUT_EN
    xfer(2, 1'b0, 0, 1'b1);
    xfer(1, 1'b0, 0, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
